// File: rtl/game_session_ctrl_if.sv
// Login/session signal bundle between the authentication block (master) and
// the game-controller session manager (slave).
interface game_session_ctrl_if;
   // LogIn is a level: InternalID is meaningful only while it is high.
   // Game_Enter and Quit_Req are one-cycle pulses and GCLogOut is a one-cycle
   // request; none of them wait for an acknowledge.
   logic       LogIn;
   logic [4:0] InternalID;
   logic       Game_Enter;
   logic       Quit_Req;
   logic       GCLogOut;
   logic       SessionActive;
   logic [4:0] ActiveID;
   logic       TimeoutWarn;
   logic [7:0] SessionCount;

   modport master (
      output LogIn, InternalID, Game_Enter, Quit_Req,
      input  GCLogOut, SessionActive, ActiveID, TimeoutWarn, SessionCount
   );

   modport slave (
      input  LogIn, InternalID, Game_Enter, Quit_Req,
      output GCLogOut, SessionActive, ActiveID, TimeoutWarn, SessionCount
   );
endinterface

// File: rtl/game_session_ctrl.sv
// Session manager: opens a session on a LogIn rising edge, forces logout on quit
// or inactivity timeout, and raises a warning window before the timeout.
module game_session_ctrl #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int WARN_CYCLES    = 200
) (
   input  logic                clk,
   input  logic                rst,
   game_session_ctrl_if.slave  gs,
   output logic [2:0]          dbgState
);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] WARN_AT   = TW'(TIMEOUT_CYCLES - WARN_CYCLES - 1);
   localparam logic [TW-1:0] LOGOUT_AT = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ACTIVE   = 3'd1,
      WARN     = 3'd2,
      LOGOUT   = 3'd3,
      WAIT_CLR = 3'd4
   } sessState_e;

   sessState_e    state, stateNext;
   logic [TW-1:0] timer, timerNext;
   logic          loginDly;
   logic          openSession;

   assign dbgState = state;

   always_comb begin
      stateNext   = state;
      timerNext   = timer;
      openSession = 1'b0;
      unique case (state)
         IDLE: begin
            if (gs.LogIn && !loginDly) begin
               stateNext   = ACTIVE;
               openSession = 1'b1;
               timerNext   = '0;
            end
         end
         ACTIVE: begin
            timerNext = gs.Game_Enter ? '0 : timer + 1'b1;
            if (!gs.LogIn)                          stateNext = IDLE;
            else if (gs.Quit_Req)                   stateNext = LOGOUT;
            else if (gs.Game_Enter)                 stateNext = ACTIVE;
            else if (timer == WARN_AT)              stateNext = WARN;
         end
         WARN: begin
            timerNext = gs.Game_Enter ? '0 : timer + 1'b1;
            if (!gs.LogIn)                          stateNext = IDLE;
            else if (gs.Quit_Req)                   stateNext = LOGOUT;
            else if (gs.Game_Enter)                 stateNext = ACTIVE;
            else if (timer == LOGOUT_AT)            stateNext = LOGOUT;
         end
         LOGOUT: begin
            stateNext = WAIT_CLR;
         end
         WAIT_CLR: begin
            // Only a LogIn drop leaves here, so a stuck-high LogIn cannot reopen.
            if (!gs.LogIn) stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they are flop outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         timer            <= '0;
         loginDly         <= 1'b0;
         gs.GCLogOut      <= 1'b0;
         gs.SessionActive <= 1'b0;
         gs.TimeoutWarn   <= 1'b0;
         gs.ActiveID      <= '0;
         gs.SessionCount  <= '0;
      end else begin
         state            <= stateNext;
         timer            <= timerNext;
         loginDly         <= gs.LogIn;
         gs.GCLogOut      <= (stateNext == LOGOUT);
         gs.SessionActive <= (stateNext == ACTIVE) || (stateNext == WARN);
         gs.TimeoutWarn   <= (stateNext == WARN);
         if (openSession) begin
            gs.ActiveID <= gs.InternalID;
            if (gs.SessionCount != 8'hFF) gs.SessionCount <= gs.SessionCount + 8'd1;
         end else if (stateNext == IDLE) begin
            gs.ActiveID <= '0;
         end
      end
   end
endmodule
